// File: rtl/dmac_bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// dmac_bus_arbiter_if
// Bundle of request, bus-status and grant signals shared between the two bus
// masters (CPU, DMAC), the AHB-style bus and the arbiter.
//
// Signals
//   cpu_req      CPU master requests the bus
//   Bus_Req      DMAC requests the bus
//   MBurst_Size  DMAC burst length in beats (0 means 16)
//   HTrans       transfer type of the current address-phase owner
//   HReady       bus ready, transfer accepted when 1
//   HResp        slave response (01 = ERROR)
//   Bus_Grant    DMAC owns the address phase
//   cpu_grant    CPU owns the address phase
//   HMaster      address-phase owner (0 CPU, 1 DMAC)
//   HMasterD     data-phase owner, used to steer read data and responses
//   burst_active DMAC burst in progress
//
// Modports
//   master  arbiter view: samples requests and bus status, drives grants
//   slave   environment view: drives requests and bus status, sees grants
// -----------------------------------------------------------------------------
interface dmac_bus_arbiter_if;
    logic       cpu_req;
    logic       Bus_Req;
    logic [3:0] MBurst_Size;
    logic [1:0] HTrans;
    logic       HReady;
    logic [1:0] HResp;
    logic       Bus_Grant;
    logic       cpu_grant;
    logic       HMaster;
    logic       HMasterD;
    logic       burst_active;

    modport master (
        input  cpu_req, Bus_Req, MBurst_Size, HTrans, HReady, HResp,
        output Bus_Grant, cpu_grant, HMaster, HMasterD, burst_active
    );

    modport slave (
        output cpu_req, Bus_Req, MBurst_Size, HTrans, HReady, HResp,
        input  Bus_Grant, cpu_grant, HMaster, HMasterD, burst_active
    );
endinterface

// File: rtl/dmac_bus_arbiter.sv
// -----------------------------------------------------------------------------
// dmac_bus_arbiter
// Two-master bus arbiter between the CPU and the DMA controller. The CPU owns
// the bus by default; the DMAC takes it for whole bursts and a fairness
// counter guarantees the CPU a minimum number of accepted transfers after
// each DMA release before the DMAC may win again.
//
// Parameters
//   CPU_MIN_SLOT  CPU accepted beats guaranteed after a DMA release (1..15)
//
// Ports
//   clk  system clock, rising edge
//   rst  asynchronous, active-low reset
//   bus  dmac_bus_arbiter_if.master (requests, bus status, grants)
//
// Every output is a flop; nothing combinational reaches the ports.
// -----------------------------------------------------------------------------
module dmac_bus_arbiter #(
    parameter int unsigned CPU_MIN_SLOT = 1
) (
    input logic                clk,
    input logic                rst,
    dmac_bus_arbiter_if.master bus
);

    typedef enum logic {
        CPU_OWN = 1'b0,
        DMA_OWN = 1'b1
    } state_e;

    localparam logic [1:0] HTRANS_IDLE = 2'b00;
    localparam logic [1:0] HTRANS_BUSY = 2'b01;
    localparam logic [1:0] HTRANS_SEQ  = 2'b11;
    localparam logic [1:0] HRESP_ERROR = 2'b01;
    localparam logic [3:0] MIN_SLOT    = 4'(CPU_MIN_SLOT);

    state_e     state_q, state_d;
    logic [4:0] beat_cnt_q, beat_cnt_d;
    logic [3:0] fair_cnt_q, fair_cnt_d;
    logic       bus_grant_q, bus_grant_d;
    logic       cpu_grant_q, cpu_grant_d;
    logic       addr_owner_q, addr_owner_d;
    logic       data_owner_q, data_owner_d;
    logic       burst_active_q, burst_active_d;

    logic       accepted;
    logic       dma_release;
    logic [4:0] burst_len;

    // NONSEQ and SEQ are the only transfer types with HTrans[1] set.
    assign accepted  = bus.HReady && bus.HTrans[1];
    assign burst_len = (bus.MBurst_Size == 4'd0) ? 5'd16 : {1'b0, bus.MBurst_Size};

    always_comb begin
        // NOTE: every variable gets a default before any branch so that no
        // path leaves it unassigned and no latch is inferred.
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        fair_cnt_d  = fair_cnt_q;
        dma_release = 1'b0;

        if (state_q == CPU_OWN) begin
            if (!bus.cpu_req) begin
                fair_cnt_d = 4'd0;
            end else if (accepted && fair_cnt_q != 4'd0) begin
                fair_cnt_d = fair_cnt_q - 4'd1;
            end

            // Hand over only on a ready cycle, with the fairness debt paid,
            // and never in the middle of a CPU burst (BUSY/SEQ).
            if (bus.Bus_Req && bus.HReady && fair_cnt_q == 4'd0 &&
                (!bus.cpu_req || bus.HTrans == HTRANS_IDLE) &&
                bus.HTrans != HTRANS_BUSY && bus.HTrans != HTRANS_SEQ) begin
                state_d    = DMA_OWN;
                beat_cnt_d = burst_len;
            end
        end else begin
            // Error response outranks everything, including a burst chain.
            if (bus.HReady && bus.HResp == HRESP_ERROR) begin
                dma_release = 1'b1;
            end else if (bus.HReady && !bus.Bus_Req && bus.HTrans == HTRANS_IDLE) begin
                dma_release = 1'b1;
            end else if (accepted) begin
                if (beat_cnt_q == 5'd1) begin
                    // Chain straight into another burst only if the CPU is idle.
                    if (bus.Bus_Req && !bus.cpu_req) begin
                        beat_cnt_d = burst_len;
                    end else begin
                        dma_release = 1'b1;
                    end
                end else if (beat_cnt_q != 5'd0) begin
                    beat_cnt_d = beat_cnt_q - 5'd1;
                end
            end

            if (dma_release) begin
                state_d    = CPU_OWN;
                beat_cnt_d = 5'd0;
                fair_cnt_d = bus.cpu_req ? MIN_SLOT : 4'd0;
            end
        end

        // Outputs are decoded from next state so the flops present them
        // exactly one cycle after the qualifying edge.
        bus_grant_d    = (state_d == DMA_OWN);
        cpu_grant_d    = (state_d == CPU_OWN);
        addr_owner_d   = (state_d == DMA_OWN);
        data_owner_d   = bus.HReady ? addr_owner_q : data_owner_q;
        burst_active_d = (beat_cnt_d != 5'd0);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= CPU_OWN;
            beat_cnt_q     <= 5'd0;
            fair_cnt_q     <= 4'd0;
            bus_grant_q    <= 1'b0;
            cpu_grant_q    <= 1'b1;
            addr_owner_q   <= 1'b0;
            data_owner_q   <= 1'b0;
            burst_active_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            beat_cnt_q     <= beat_cnt_d;
            fair_cnt_q     <= fair_cnt_d;
            bus_grant_q    <= bus_grant_d;
            cpu_grant_q    <= cpu_grant_d;
            addr_owner_q   <= addr_owner_d;
            data_owner_q   <= data_owner_d;
            burst_active_q <= burst_active_d;
        end
    end

    assign bus.Bus_Grant    = bus_grant_q;
    assign bus.cpu_grant    = cpu_grant_q;
    assign bus.HMaster      = addr_owner_q;
    assign bus.HMasterD     = data_owner_q;
    assign bus.burst_active = burst_active_q;

endmodule

// File: tb/tb_dmac_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmac_bus_arbiter
// Self-checking bench for dmac_bus_arbiter (CPU_MIN_SLOT = 2). Directed
// scenarios plus a randomized run, all compared cycle by cycle against a
// behavioural model of bus ownership, remaining burst beats and CPU credit.
// -----------------------------------------------------------------------------
module tb_dmac_bus_arbiter;

    localparam int MIN_SLOT = 2;
    localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NONSEQ = 2'b10, SEQ = 2'b11;
    localparam logic [1:0] OKAY = 2'b00, ERROR = 2'b01;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    dmac_bus_arbiter_if bus();

    dmac_bus_arbiter #(.CPU_MIN_SLOT(MIN_SLOT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- reference model ----------------
    bit m_dma;          // DMAC holds the address phase
    int m_beats;        // beats left in the current DMA burst
    int m_credit;       // CPU beats still owed before DMAC may win again
    bit m_data_owner;   // owner of the data phase

    task automatic model_reset();
        m_dma = 0; m_beats = 0; m_credit = 0; m_data_owner = 0;
    endtask

    task automatic model_step();
        bit accepted  = bus.HReady && (bus.HTrans == NONSEQ || bus.HTrans == SEQ);
        int len       = (bus.MBurst_Size == 0) ? 16 : int'(bus.MBurst_Size);
        bit give_back = 0;
        if (bus.HReady) m_data_owner = m_dma;
        if (!m_dma) begin
            bit cpu_can_yield = !bus.cpu_req || bus.HTrans == IDLE;
            bit cpu_mid_burst = bus.HTrans == BUSY || bus.HTrans == SEQ;
            if (bus.Bus_Req && bus.HReady && m_credit == 0 && cpu_can_yield && !cpu_mid_burst) begin
                m_dma   = 1;
                m_beats = len;
            end else if (!bus.cpu_req) begin
                m_credit = 0;
            end else if (accepted && m_credit > 0) begin
                m_credit = m_credit - 1;
            end
        end else begin
            if (bus.HReady && bus.HResp == ERROR) give_back = 1;
            else if (bus.HReady && !bus.Bus_Req && bus.HTrans == IDLE) give_back = 1;
            else if (accepted && m_beats == 1) begin
                if (bus.Bus_Req && !bus.cpu_req) m_beats = len;
                else give_back = 1;
            end else if (accepted && m_beats > 0) m_beats = m_beats - 1;
            if (give_back) begin
                m_dma    = 0;
                m_beats  = 0;
                m_credit = bus.cpu_req ? MIN_SLOT : 0;
            end
        end
    endtask

    // {Bus_Grant, cpu_grant, HMaster, HMasterD, burst_active}
    function automatic logic [4:0] model_out();
        return {m_dma, !m_dma, m_dma, m_data_owner, m_beats != 0};
    endfunction

    function automatic logic [4:0] dut_out();
        return {bus.Bus_Grant, bus.cpu_grant, bus.HMaster, bus.HMasterD, bus.burst_active};
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic c, input logic b, input logic [3:0] sz,
                         input logic [1:0] ht, input logic hr, input logic [1:0] hp);
        bus.cpu_req = c; bus.Bus_Req = b; bus.MBurst_Size = sz;
        bus.HTrans = ht; bus.HReady = hr; bus.HResp = hp;
    endtask

    task automatic cyc(input logic c, input logic b, input logic [3:0] sz,
                       input logic [1:0] ht, input logic hr, input logic [1:0] hp);
        drive(c, b, sz, ht, hr, hp);
        @(posedge clk);
        model_step();
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b0;
        drive(0, 0, 4'd4, IDLE, 1, OKAY);
        model_reset();
        #12;
        checks++;
        if (dut_out() !== 5'b01000) begin
            errors++;
            $display("FAIL reset_state: got %b expected %b", dut_out(), 5'b01000);
        end
        @(negedge clk);
        rst = 1'b1;
        cyc(0, 0, 4'd4, IDLE, 1, OKAY);
        checks++;
        if (dut_out() !== model_out()) begin
            errors++;
            $display("FAIL reset_release: got %b expected %b", dut_out(), model_out());
        end
    endtask

    task automatic test_basic_burst();
        cyc(0, 1, 4'd4, IDLE, 1, OKAY);
        checks++;
        if (bus.Bus_Grant !== 1'b1 || bus.cpu_grant !== 1'b0) begin
            errors++;
            $display("FAIL basic_grant: got bg=%b cg=%b expected bg=1 cg=0", bus.Bus_Grant, bus.cpu_grant);
        end
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 4'd4, (i == 0) ? NONSEQ : SEQ, 1, OKAY);
            checks++;
            if (dut_out() !== model_out()) begin
                errors++;
                $display("FAIL basic_beat%0d: got %b expected %b", i + 1, dut_out(), model_out());
            end
        end
        checks++;
        if (bus.cpu_grant !== 1'b1 || bus.Bus_Grant !== 1'b0) begin
            errors++;
            $display("FAIL basic_release: got cg=%b bg=%b expected cg=1 bg=0", bus.cpu_grant, bus.Bus_Grant);
        end
        cyc(0, 0, 4'd4, IDLE, 1, OKAY);
    endtask

    task automatic test_wait_states();
        cyc(0, 1, 4'd4, IDLE, 1, OKAY);
        cyc(0, 0, 4'd4, NONSEQ, 1, OKAY);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 4'd4, SEQ, 0, OKAY);
            checks++;
            if (bus.Bus_Grant !== 1'b1 || bus.burst_active !== 1'b1 || dut_out() !== model_out()) begin
                errors++;
                $display("FAIL wait_hold%0d: got %b expected %b", i, dut_out(), model_out());
            end
        end
        for (int i = 2; i <= 4; i++) begin
            cyc(0, 0, 4'd4, SEQ, 1, OKAY);
            checks++;
            if (bus.Bus_Grant !== ((i == 4) ? 1'b0 : 1'b1) || dut_out() !== model_out()) begin
                errors++;
                $display("FAIL wait_beat%0d: got %b expected %b", i, dut_out(), model_out());
            end
        end
        cyc(0, 0, 4'd4, IDLE, 1, OKAY);
    endtask

    task automatic test_fairness();
        // Both request, CPU idle, no credit owed: DMAC wins.
        cyc(1, 1, 4'd4, IDLE, 1, OKAY);
        checks++;
        if (bus.Bus_Grant !== 1'b1) begin
            errors++;
            $display("FAIL fair_simul_req: got bg=%b expected bg=1", bus.Bus_Grant);
        end
        for (int i = 0; i < 4; i++) begin
            cyc(1, 1, 4'd4, (i == 0) ? NONSEQ : SEQ, 1, OKAY);
            checks++;
            if (dut_out() !== model_out()) begin
                errors++;
                $display("FAIL fair_dma_beat%0d: got %b expected %b", i + 1, dut_out(), model_out());
            end
        end
        checks++;
        if (bus.cpu_grant !== 1'b1) begin
            errors++;
            $display("FAIL fair_release: got cg=%b expected cg=1", bus.cpu_grant);
        end
        // One CPU beat, then an idle slot: one beat still owed, so CPU keeps it.
        cyc(1, 1, 4'd4, NONSEQ, 1, OKAY);
        cyc(1, 1, 4'd4, IDLE, 1, OKAY);
        checks++;
        if (bus.cpu_grant !== 1'b1 || dut_out() !== model_out()) begin
            errors++;
            $display("FAIL fair_one_beat: got %b expected %b", dut_out(), model_out());
        end
        cyc(1, 1, 4'd4, NONSEQ, 1, OKAY);
        checks++;
        if (bus.cpu_grant !== 1'b1) begin
            errors++;
            $display("FAIL fair_two_beats: got cg=%b expected cg=1", bus.cpu_grant);
        end
        cyc(1, 1, 4'd4, IDLE, 1, OKAY);
        checks++;
        if (bus.Bus_Grant !== 1'b1 || dut_out() !== model_out()) begin
            errors++;
            $display("FAIL fair_regrant: got %b expected %b", dut_out(), model_out());
        end
        for (int i = 0; i < 4; i++) cyc(0, 0, 4'd4, SEQ, 1, OKAY);
        cyc(0, 0, 4'd4, IDLE, 1, OKAY);
        checks++;
        if (dut_out() !== model_out()) begin
            errors++;
            $display("FAIL fair_drain: got %b expected %b", dut_out(), model_out());
        end
    endtask

    task automatic test_error();
        cyc(0, 1, 4'd4, IDLE, 1, OKAY);
        cyc(0, 1, 4'd4, NONSEQ, 1, OKAY);
        cyc(0, 1, 4'd4, SEQ, 1, ERROR);
        checks++;
        if (bus.cpu_grant !== 1'b1 || bus.burst_active !== 1'b0 || dut_out() !== model_out()) begin
            errors++;
            $display("FAIL error_abort: got %b expected %b", dut_out(), model_out());
        end
        cyc(0, 0, 4'd4, IDLE, 1, OKAY);
    endtask

    task automatic test_burst16_reset();
        cyc(0, 1, 4'd0, IDLE, 1, OKAY);
        for (int i = 1; i <= 16; i++) begin
            cyc(0, 0, 4'd0, SEQ, 1, OKAY);
            checks++;
            if (bus.Bus_Grant !== ((i == 16) ? 1'b0 : 1'b1) || dut_out() !== model_out()) begin
                errors++;
                $display("FAIL burst16_beat%0d: got %b expected %b", i, dut_out(), model_out());
            end
        end
        cyc(0, 1, 4'd0, IDLE, 1, OKAY);
        for (int i = 1; i <= 6; i++) cyc(0, 0, 4'd0, SEQ, 1, OKAY);
        drive(0, 0, 4'd0, SEQ, 1, OKAY);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        checks++;
        if (dut_out() !== 5'b01000) begin
            errors++;
            $display("FAIL reset_mid_burst: got %b expected %b", dut_out(), 5'b01000);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b1;
        cyc(0, 0, 4'd0, SEQ, 1, OKAY);
        checks++;
        if (dut_out() !== model_out()) begin
            errors++;
            $display("FAIL reset_no_retain: got %b expected %b", dut_out(), model_out());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            logic [1:0] hp = ($urandom_range(0, 15) == 0) ? ERROR : OKAY;
            cyc(logic'($urandom_range(0, 1)), logic'($urandom_range(0, 9) < 6),
                4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                logic'($urandom_range(0, 3) != 0), hp);
            checks++;
            if (dut_out() !== model_out()) begin
                errors++;
                $display("FAIL random_cycle%0d: got %b expected %b", i, dut_out(), model_out());
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_burst();
        test_wait_states();
        test_fairness();
        test_error();
        test_burst16_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmac_bus_arbiter.md
DMAC_BUS_ARBITER -- requirements
Module: dmac_bus_arbiter

Interface
REQ-001 SHALL provide parameter: CPU_MIN_SLOT, 1, minimum accepted CPU transfers after a DMA release before DMA may regain the bus (legal 1..15).
REQ-002 SHALL provide port: clk  input  1  system clock, all state on rising edge.
REQ-003 SHALL provide port: rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL provide port: cpu_req  input  1  CPU master requests bus.
REQ-005 SHALL provide port: Bus_Req  input  1  DMAC requests bus.
REQ-006 SHALL provide port: MBurst_Size  input  4  DMAC burst length in beats, 0 means 16.
REQ-007 SHALL provide port: HTrans  input  2  transfer type from current address-phase owner (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ).
REQ-008 SHALL provide port: HReady  input  1  bus ready, transfer accepted when 1.
REQ-009 SHALL provide port: HResp  input  2  slave response, 01 = ERROR.
REQ-010 SHALL provide port: Bus_Grant  output  1  DMAC owns address phase.
REQ-011 SHALL provide port: cpu_grant  output  1  CPU owns address phase.
REQ-012 SHALL provide port: HMaster  output  1  address-phase owner, 0 CPU, 1 DMAC.
REQ-013 SHALL provide port: HMasterD  output  1  data-phase owner for read-data/response steering.
REQ-014 SHALL provide port: burst_active  output  1  DMAC burst in progress (beat counter nonzero).

Function
REQ-015 SHALL implement FSM with states CPU_OWN and DMA_OWN; all outputs registered or decoded from registered state only.
REQ-016 SHALL define "accepted beat" as HReady=1 and HTrans in {10,11} in a given cycle.
REQ-017 CPU_OWN: cpu_grant=1, Bus_Grant=0, HMaster=0.
REQ-018 CPU_OWN -> DMA_OWN when Bus_Req=1, HReady=1, fair_cnt=0, and (cpu_req=0 or HTrans=00); never during CPU SEQ/BUSY.
REQ-019 On entry to DMA_OWN SHALL load beat_cnt = MBurst_Size (0 loads 16); beat_cnt 5-bit.
REQ-020 DMA_OWN: Bus_Grant=1, cpu_grant=0, HMaster=1, burst_active=(beat_cnt!=0).
REQ-021 In DMA_OWN each accepted beat SHALL decrement beat_cnt by 1; beat_cnt SHALL NOT wrap below 0.
REQ-022 On accepted beat with beat_cnt=1: if Bus_Req=1 and cpu_req=0, stay DMA_OWN and reload beat_cnt from MBurst_Size; else -> CPU_OWN.
REQ-023 In DMA_OWN with Bus_Req=0, HReady=1, HTrans=00, SHALL go CPU_OWN and clear beat_cnt (burst abandoned).
REQ-024 In DMA_OWN, HResp=01 with HReady=1 SHALL force -> CPU_OWN and clear beat_cnt, overriding REQ-022.
REQ-025 On every DMA_OWN -> CPU_OWN transition with cpu_req=1, fair_cnt SHALL load CPU_MIN_SLOT; otherwise fair_cnt loads 0.
REQ-026 In CPU_OWN each accepted beat SHALL decrement fair_cnt (saturating at 0); cpu_req=0 SHALL clear fair_cnt.
REQ-027 HMasterD SHALL load HMaster when HReady=1, hold otherwise.
REQ-028 Grant change SHALL appear on outputs exactly one cycle after the qualifying edge; never both grants high; exactly one grant high out of reset.
REQ-029 Simultaneous Bus_Req and cpu_req in CPU_OWN with fair_cnt=0 and HTrans=00: DMAC wins.

Reset
REQ-030 rst=0 SHALL asynchronously force CPU_OWN, cpu_grant=1, Bus_Grant=0, HMaster=0, HMasterD=0, burst_active=0, beat_cnt=0, fair_cnt=0.
REQ-031 Reset mid-burst SHALL drop Bus_Grant immediately (same cycle rst asserts); no state retained after release.

Verification
REQ-032 Bus_Req=1, MBurst_Size=4, cpu_req=0, HReady=1, HTrans 00 -> Bus_Grant=1 next cycle; after 4 accepted beats with Bus_Req=0, cpu_grant=1 next cycle.
REQ-033 DMA burst of 4 with HReady=0 on beat 2 for 3 cycles -> beat_cnt holds, Bus_Grant stays 1, release only after 4th accepted beat.
REQ-034 CPU_MIN_SLOT=2, cpu_req=1 and Bus_Req=1 continuously -> after DMA burst CPU keeps grant for exactly 2 accepted beats, then DMA regrants.
REQ-035 DMA_OWN, beat 2 returns HResp=01 with HReady=1 -> cpu_grant=1 next cycle, burst_active=0.
REQ-036 MBurst_Size=0 -> 16 accepted beats before release; rst=0 asserted at beat 7 -> Bus_Grant=0 immediately, cpu_grant=1.
